// File: rtl/otp_cg_pkg.sv
// Shared types and constants for the OTP clock-gating controller.
//
// Contents:
//   cg_state_t - per-channel gate FSM state
//   CG_ACT_W   - width of the active-channel count output
//   cgMax      - helper used to size the per-channel counter
package otp_cg_pkg;

    typedef enum logic [1:0] {
        CG_OFF  = 2'd0,
        CG_WAKE = 2'd1,
        CG_ON   = 2'd2,
        CG_IDLE = 2'd3
    } cg_state_t;

    localparam int CG_ACT_W = 5;

    function automatic int cgMax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/otp_icg_cell.sv
// Behavioural integrated clock-gating cell (latch + AND).
// This model is replaced by the library ICG cell (CKLNQD8) in synthesis.
//
// Ports:
//   CP - free-running clock
//   E  - gate enable, expected to change only at rising CP
//   TE - scan test enable, opens the gate unconditionally
//   Q  - gated clock
module otp_icg_cell (
    input  logic CP,
    input  logic E,
    input  logic TE,
    output logic Q
);

    logic enLatch_q;

    // The enable is captured only while CP is low. It is therefore frozen for the
    // whole high phase, so Q can never be shortened or pulsed mid-cycle.
    always_latch begin
        if (!CP) begin
            enLatch_q <= E | TE;
        end
    end

    assign Q = CP & enLatch_q;

endmodule

// File: rtl/otp_clk_gate_ctrl.sv
// Multi-channel clock-gating controller for the OTP fuse-array, charge-pump and
// sense-amp domains. Each channel runs a small FSM that opens its gate on request,
// acknowledges after a fixed wake latency, and closes the gate again after a
// programmable idle timeout. Scan test enable forces every gated clock on.
//
// Ports:
//   CP           - free-running clock
//   RST          - synchronous active-high reset
//   TE           - scan test enable, forces every CPG to follow CP
//   REQ          - per-channel clock request
//   FORCE_ON     - per-channel keep-on, behaves like REQ
//   BUSY         - per-channel activity, holds an ON/IDLE channel awake
//   IDLE_TIMEOUT - idle cycles before a released channel is gated
//   ACK          - registered: gated clock is running and stable
//   CLK_EN       - registered gate enable (before the ICG latch)
//   CPG          - gated clocks
//   ACT_CNT      - registered number of enabled channels
module otp_clk_gate_ctrl
    import otp_cg_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int IDLE_W   = 8,
    parameter int WAKE_CYC = 2
) (
    input  logic                CP,
    input  logic                RST,
    input  logic                TE,
    input  logic [NUM_CH-1:0]   REQ,
    input  logic [NUM_CH-1:0]   FORCE_ON,
    input  logic [NUM_CH-1:0]   BUSY,
    input  logic [IDLE_W-1:0]   IDLE_TIMEOUT,
    output logic [NUM_CH-1:0]   ACK,
    output logic [NUM_CH-1:0]   CLK_EN,
    output logic [NUM_CH-1:0]   CPG,
    output logic [CG_ACT_W-1:0] ACT_CNT
);

    localparam int CNT_W = cgMax(IDLE_W, $clog2(WAKE_CYC));
    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYC - 1);

    logic [CNT_W-1:0]    idleLoad;
    logic [CG_ACT_W-1:0] actCnt_d;
    logic [CG_ACT_W-1:0] actCnt_q;

    assign idleLoad = CNT_W'(IDLE_TIMEOUT);

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch

        cg_state_t        state_q;
        cg_state_t        state_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic [CNT_W-1:0] cntInc;
        logic             wake;
        logic             ack_q;
        logic             clkEn_q;

        assign wake   = REQ[ch] | FORCE_ON[ch];
        assign cntInc = cnt_q + CNT_W'(1);

        // Next-state logic for one channel. In WAKE the comparison uses the
        // incremented count so that ACK rises WAKE_CYC-1 edges after the gate
        // opened; with WAKE_CYC of 1 the WAKE state is skipped entirely. A
        // request always beats BUSY, and in IDLE it returns straight to ON
        // because the clock never stopped.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            unique case (state_q)
                CG_OFF: begin
                    if (wake) begin
                        state_d = (WAKE_CYC == 1) ? CG_ON : CG_WAKE;
                        cnt_d   = '0;
                    end
                end
                CG_WAKE: begin
                    if (!wake) begin
                        state_d = CG_IDLE;
                        cnt_d   = idleLoad;
                    end else begin
                        cnt_d = cntInc;
                        if (cntInc == WAKE_LAST) begin
                            state_d = CG_ON;
                        end
                    end
                end
                CG_ON: begin
                    if (!wake && !BUSY[ch]) begin
                        state_d = CG_IDLE;
                        cnt_d   = idleLoad;
                    end
                end
                CG_IDLE: begin
                    if (wake) begin
                        state_d = CG_ON;
                    end else if (BUSY[ch]) begin
                        cnt_d = idleLoad;
                    end else if (cnt_q == '0) begin
                        state_d = CG_OFF;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = CG_OFF;
                end
            endcase
        end

        // State, counter and the registered status bits. ACK and CLK_EN are
        // decoded from the next state so they change on the same edge as the FSM.
        always_ff @(posedge CP) begin
            if (RST) begin
                state_q <= CG_OFF;
                cnt_q   <= '0;
                ack_q   <= 1'b0;
                clkEn_q <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                ack_q   <= (state_d == CG_ON);
                clkEn_q <= (state_d != CG_OFF);
            end
        end

        assign ACK[ch]    = ack_q;
        assign CLK_EN[ch] = clkEn_q;

        otp_icg_cell u_icg (
            .CP (CP),
            .E  (clkEn_q),
            .TE (TE),
            .Q  (CPG[ch])
        );
    end

    // Population count of the current gate enables; the result is registered,
    // so it trails CLK_EN by one edge.
    always_comb begin
        actCnt_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            actCnt_d = actCnt_d + CG_ACT_W'(CLK_EN[i]);
        end
    end

    // Active-channel count register.
    always_ff @(posedge CP) begin
        if (RST) begin
            actCnt_q <= '0;
        end else begin
            actCnt_q <= actCnt_d;
        end
    end

    assign ACT_CNT = actCnt_q;

endmodule

// File: tb/tb_otp_clk_gate_ctrl.sv
`timescale 1ns/1ps
// Directed bench for otp_clk_gate_ctrl. Instance A uses WAKE_CYC=2, instance B
// uses WAKE_CYC=4 to exercise the longer wake latency and the aborted wake.
module tb_otp_clk_gate_ctrl;

    logic       cp = 1'b0;
    logic       rst;
    logic       te;
    logic [3:0] req;
    logic [3:0] forceOn;
    logic [3:0] busy;
    logic [7:0] idleTimeout;
    logic [3:0] ack;
    logic [3:0] clkEn;
    logic [3:0] cpg;
    logic [4:0] actCnt;

    logic [3:0] reqB;
    logic [3:0] forceOnB;
    logic [3:0] ackB;
    logic [3:0] clkEnB;
    logic [3:0] cpgB;
    logic [4:0] actCntB;

    logic [3:0] cpgSnap;
    logic [3:0] cpgSnapB;

    int checks = 0;
    int errors = 0;
    int glitchCnt = 0;

    logic [7:0] prevCpg = '0;
    time        riseT [8];

    otp_clk_gate_ctrl #(.NUM_CH(4), .IDLE_W(8), .WAKE_CYC(2)) dutA (
        .CP           (cp),
        .RST          (rst),
        .TE           (te),
        .REQ          (req),
        .FORCE_ON     (forceOn),
        .BUSY         (busy),
        .IDLE_TIMEOUT (idleTimeout),
        .ACK          (ack),
        .CLK_EN       (clkEn),
        .CPG          (cpg),
        .ACT_CNT      (actCnt)
    );

    otp_clk_gate_ctrl #(.NUM_CH(4), .IDLE_W(8), .WAKE_CYC(4)) dutB (
        .CP           (cp),
        .RST          (rst),
        .TE           (te),
        .REQ          (reqB),
        .FORCE_ON     (forceOnB),
        .BUSY         (busy),
        .IDLE_TIMEOUT (idleTimeout),
        .ACK          (ackB),
        .CLK_EN       (clkEnB),
        .CPG          (cpgB),
        .ACT_CNT      (actCntB)
    );

    // Free-running clock, 10 ns period, rising edges at 5, 15, 25 ...
    always #5 cp = ~cp;

    // Watches every gated clock and counts any high pulse shorter than half a period.
    always @(cpg or cpgB) begin
        logic [7:0] cur;
        cur = {cpgB, cpg};
        for (int i = 0; i < 8; i++) begin
            if (cur[i] === 1'b1 && prevCpg[i] !== 1'b1) begin
                riseT[i] = $time;
            end else if (cur[i] !== 1'b1 && prevCpg[i] === 1'b1) begin
                if ($time - riseT[i] < 5) begin
                    glitchCnt++;
                end
            end
        end
        prevCpg = cur;
    end

    // Advance n rising edges, then settle on the following falling edge where
    // outputs are sampled and new inputs are driven.
    task automatic applyStimulus(input int n);
        repeat (n) @(posedge cp);
        @(negedge cp);
    endtask

    // Advance one rising edge, capture the gated clocks in the middle of the
    // high phase, then settle on the falling edge.
    task automatic sampleHigh();
        @(posedge cp);
        #2;
        cpgSnap  = cpg;
        cpgSnapB = cpgB;
        @(negedge cp);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst         = 1'b1;
        te          = 1'b0;
        req         = 4'hF;
        forceOn     = 4'h0;
        busy        = 4'h0;
        idleTimeout = 8'd3;
        reqB        = 4'hF;
        forceOnB    = 4'h0;

        // Reset held for three edges with every request high.
        applyStimulus(3);
        checkOutput("rst_ack", ack, 4'h0);
        checkOutput("rst_clken", clkEn, 4'h0);
        checkOutput("rst_actcnt", actCnt, 5'd0);
        checkOutput("rst_ackB", ackB, 4'h0);
        sampleHigh();
        checkOutput("rst_cpg", cpgSnap, 4'h0);

        // Wake channel 0: gate opens after edge k, clock at k+1, ACK after k+1.
        rst  = 1'b0;
        req  = 4'h0;
        reqB = 4'h0;
        applyStimulus(1);
        req = 4'h1;
        sampleHigh();
        checkOutput("wake_cpg_k", cpgSnap, 4'h0);
        checkOutput("wake_clken_k", clkEn, 4'h1);
        checkOutput("wake_ack_k", ack, 4'h0);
        checkOutput("wake_actcnt_k", actCnt, 5'd0);
        sampleHigh();
        checkOutput("wake_cpg_k1", cpgSnap, 4'h1);
        checkOutput("wake_ack_k1", ack, 4'h1);
        checkOutput("wake_actcnt_k1", actCnt, 5'd1);

        // Idle timeout of 3 on channel 1: gate closes four edges after release.
        req = 4'h3;
        applyStimulus(2);
        checkOutput("idle_ack_on", ack, 4'h3);
        req = 4'h1;
        applyStimulus(1);
        checkOutput("idle_ack_drop", ack, 4'h1);
        checkOutput("idle_clken_drop", clkEn, 4'h3);
        applyStimulus(3);
        checkOutput("idle_clken_cnt0", clkEn, 4'h3);
        applyStimulus(1);
        checkOutput("idle_clken_off", clkEn, 4'h1);
        checkOutput("idle_actcnt_two", actCnt, 5'd2);
        sampleHigh();
        checkOutput("idle_cpg_off", cpgSnap, 4'h1);
        checkOutput("idle_actcnt_one", actCnt, 5'd1);

        // BUSY seen two edges into the countdown reloads it, stretching to seven edges.
        req = 4'h3;
        applyStimulus(2);
        req = 4'h1;
        applyStimulus(3);
        busy = 4'h2;
        applyStimulus(1);
        busy = 4'h0;
        applyStimulus(3);
        checkOutput("busy_clken_held", clkEn, 4'h3);
        applyStimulus(1);
        checkOutput("busy_clken_off", clkEn, 4'h1);

        // Release and BUSY on the same edge in ON keeps the channel ON.
        req = 4'h3;
        applyStimulus(2);
        req  = 4'h1;
        busy = 4'h2;
        applyStimulus(1);
        checkOutput("busy_hold_ack", ack, 4'h3);
        busy = 4'h0;
        applyStimulus(1);
        checkOutput("busy_release_ack", ack, 4'h1);

        // Request and BUSY together in IDLE: request wins, ACK returns next edge.
        req  = 4'h3;
        busy = 4'h2;
        applyStimulus(1);
        checkOutput("idle_rewake_ack", ack, 4'h3);

        // Zero timeout: IDLE lasts a single edge.
        busy        = 4'h0;
        idleTimeout = 8'd0;
        req         = 4'h1;
        applyStimulus(1);
        checkOutput("zero_to_clken_idle", clkEn, 4'h3);
        checkOutput("zero_to_ack_idle", ack, 4'h1);
        applyStimulus(1);
        checkOutput("zero_to_clken_off", clkEn, 4'h1);
        idleTimeout = 8'd3;

        // Fast re-wake of channel 2: clock keeps running through the short IDLE.
        req = 4'h5;
        applyStimulus(2);
        checkOutput("rewake_ack_on", ack, 4'h5);
        req = 4'h1;
        applyStimulus(1);
        checkOutput("rewake_ack_drop", ack, 4'h1);
        sampleHigh();
        checkOutput("rewake_cpg_d1", cpgSnap, 4'h5);
        checkOutput("rewake_ack_d1", ack, 4'h1);
        req = 4'h5;
        sampleHigh();
        checkOutput("rewake_cpg_d2", cpgSnap, 4'h5);
        checkOutput("rewake_ack_d2", ack, 4'h5);

        // Instance B: one-cycle pulse on channel 3 aborts the wake, never ACKs.
        reqB = 4'h8;
        applyStimulus(1);
        checkOutput("abort_clken_wake", clkEnB, 4'h8);
        checkOutput("abort_ack_wake", ackB, 4'h0);
        reqB = 4'h0;
        applyStimulus(1);
        checkOutput("abort_clken_idle", clkEnB, 4'h8);
        checkOutput("abort_ack_idle", ackB, 4'h0);

        // Instance B: held request on channel 0 is acknowledged after edge k+3.
        reqB = 4'h1;
        applyStimulus(3);
        checkOutput("wake4_ack_early", ackB, 4'h0);
        applyStimulus(1);
        checkOutput("wake4_ack", ackB, 4'h1);
        checkOutput("wake4_clken", clkEnB, 4'h1);

        // Scan override with every channel OFF.
        req         = 4'h0;
        reqB        = 4'h0;
        idleTimeout = 8'd0;
        applyStimulus(2);
        checkOutput("te_pre_clken", clkEn, 4'h0);
        checkOutput("te_pre_clkenB", clkEnB, 4'h0);
        te = 1'b1;
        sampleHigh();
        checkOutput("te_cpg", cpgSnap, 4'hF);
        checkOutput("te_cpgB", cpgSnapB, 4'hF);
        checkOutput("te_ack", ack, 4'h0);
        checkOutput("te_clken", clkEn, 4'h0);
        te = 1'b0;
        sampleHigh();
        checkOutput("te_off_cpg", cpgSnap, 4'h0);

        // Reset while all channels are ON (two via FORCE_ON).
        idleTimeout = 8'd3;
        req         = 4'h3;
        forceOn     = 4'hC;
        applyStimulus(2);
        checkOutput("mid_rst_ack_on", ack, 4'hF);
        rst = 1'b1;
        sampleHigh();
        checkOutput("mid_rst_cpg_run", cpgSnap, 4'hF);
        checkOutput("mid_rst_ack", ack, 4'h0);
        checkOutput("mid_rst_clken", clkEn, 4'h0);
        checkOutput("mid_rst_actcnt", actCnt, 5'd0);
        rst     = 1'b0;
        req     = 4'h0;
        forceOn = 4'h0;
        sampleHigh();
        checkOutput("mid_rst_cpg_stop", cpgSnap, 4'h0);
        checkOutput("glitch_count", glitchCnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
